// File: rtl/datapath_mc_types.sv
// Shared types for the multicycle datapath: control-select encodings,
// memory access widths, sequencer states, ALU op codes and byte-mask helper.
// Pure declarations; no logic or state.
package datapath_mc_types;

   typedef enum logic [1:0] {
      RF_D_ALU_R = 2'd0,
      RF_D_MDR   = 2'd1,
      RF_D_ALU_W = 2'd2
   } rf_d_sel_t;

   typedef enum logic {ALU_X_REGFILE = 1'b0, ALU_X_PC    = 1'b1} alu_x_sel_t;
   typedef enum logic {ALU_Y_REGFILE = 1'b0, ALU_Y_IMMED = 1'b1} alu_y_sel_t;
   typedef enum logic {MEM_ADDR_PC   = 1'b0, MEM_ADDR_ALU_R = 1'b1} mem_addr_sel_t;
   typedef enum logic {MEM_DST_IR    = 1'b0, MEM_DST_MDR = 1'b1} mem_dst_t;

   typedef enum logic [1:0] {
      MEM_BYTE  = 2'd0,
      MEM_HALF  = 2'd1,
      MEM_WORD  = 2'd2,
      MEM_DWORD = 2'd3
   } mem_width_t;

   typedef enum logic [1:0] {
      MEM_IDLE = 2'd0,
      MEM_REQ  = 2'd1,
      MEM_RESP = 2'd2
   } mem_state_t;

   localparam logic [3:0] ALU_ADD    = 4'd0;
   localparam logic [3:0] ALU_SUB    = 4'd1;
   localparam logic [3:0] ALU_AND    = 4'd2;
   localparam logic [3:0] ALU_OR     = 4'd3;
   localparam logic [3:0] ALU_XOR    = 4'd4;
   localparam logic [3:0] ALU_SLL    = 4'd5;
   localparam logic [3:0] ALU_SRL    = 4'd6;
   localparam logic [3:0] ALU_SRA    = 4'd7;
   localparam logic [3:0] ALU_SLT    = 4'd8;
   localparam logic [3:0] ALU_SLTU   = 4'd9;
   localparam logic [3:0] ALU_PASS_Y = 4'd10;

   // Byte-enable pattern of an access at offset 0 (up to 8 lanes).
   function automatic logic [7:0] width_mask(input mem_width_t w);
      case (w)
         MEM_BYTE: return 8'h01;
         MEM_HALF: return 8'h03;
         MEM_WORD: return 8'h0F;
         default:  return 8'hFF;
      endcase
   endfunction

endpackage

// File: rtl/alu.sv
// Combinational integer ALU, XLEN wide.
// Latency: 0 cycles. No flow control.
// Ports: op (ALU op code), x/y operands, w result.
module alu
   import datapath_mc_types::*;
#(
   parameter int XLEN = 32
) (
   input  logic [3:0]      op,
   input  logic [XLEN-1:0] x,
   input  logic [XLEN-1:0] y,
   output logic [XLEN-1:0] w
);

   localparam int SHW = $clog2(XLEN);

   logic [SHW-1:0] shamt;
   assign shamt = y[SHW-1:0];

   always_comb begin
      w = '0;
      case (op)
         ALU_ADD:    w = x + y;
         ALU_SUB:    w = x - y;
         ALU_AND:    w = x & y;
         ALU_OR:     w = x | y;
         ALU_XOR:    w = x ^ y;
         ALU_SLL:    w = x << shamt;
         ALU_SRL:    w = x >> shamt;
         ALU_SRA:    w = $unsigned($signed(x) >>> shamt);
         ALU_SLT:    w = {{(XLEN-1){1'b0}}, ($signed(x) < $signed(y))};
         ALU_SLTU:   w = {{(XLEN-1){1'b0}}, (x < y)};
         ALU_PASS_Y: w = y;
         default:    w = '0;
      endcase
   end

endmodule

// File: rtl/mem_sequencer.sv
// Valid/ready memory sequencer: alignment check, byte-lane steering, load extension.
// Latency: start at N -> mem_valid at N+1 -> done one cycle after the ready handshake.
// Backpressure: request and all mem_* outputs held stable while mem_ready is low.
// Ports: start/we/addr/width/uns/dst/wsrc from the datapath; busy/done/fault status;
//        mem_* request channel; load_vld/load_dst/load_dat deliver extracted load data.
module mem_sequencer
   import datapath_mc_types::*;
#(
   parameter int XLEN = 32
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic              we,
   input  logic [XLEN-1:0]   addr,
   input  logic [XLEN-1:0]   wsrc,
   input  logic [1:0]        width,
   input  logic              uns,
   input  logic              dst,
   output logic              busy,
   output logic              done,
   output logic              fault,
   output logic              mem_valid,
   input  logic              mem_ready,
   output logic              mem_we,
   output logic [XLEN-1:0]   mem_addr,
   output logic [XLEN/8-1:0] mem_be,
   output logic [XLEN-1:0]   mem_wdata,
   input  logic [XLEN-1:0]   mem_rdata,
   output logic              load_vld,
   output logic              load_dst,
   output logic [XLEN-1:0]   load_dat
);

   localparam int NB   = XLEN / 8;
   localparam int OFFW = $clog2(NB);

   mem_state_t      state_q, state_d;
   logic            fault_q;
   logic            we_q, uns_q, dst_q;
   logic [1:0]      width_q;
   logic [OFFW-1:0] off_q;
   logic [XLEN-1:0] addr_q, wdata_q;
   logic [NB-1:0]   be_q;

   logic            misalign, accept;
   logic [OFFW-1:0] off;
   logic [7:0]      mask8;
   logic [NB-1:0]   be_d;
   logic [XLEN-1:0] wdata_d;
   logic [XLEN-1:0] shifted, keep;
   logic            msb;

   assign off = addr[OFFW-1:0];

   // DWORD is only legal when the bus is 64 bits wide.
   always_comb begin
      misalign = 1'b0;
      case (width)
         MEM_BYTE: misalign = 1'b0;
         MEM_HALF: misalign = addr[0];
         MEM_WORD: misalign = |addr[1:0];
         default:  misalign = (XLEN == 32) || (|addr[2:0]);
      endcase
   end

   assign accept = (state_q == MEM_IDLE) && start && !misalign;

   assign mask8 = width_mask(mem_width_t'(width));
   assign be_d  = NB'(mask8 << off);

   // Replicate the low bytes of the store source across every lane so the
   // enabled lanes carry the right data regardless of offset.
   always_comb begin
      case (width)
         MEM_BYTE: wdata_d = {NB{wsrc[7:0]}};
         MEM_HALF: wdata_d = {(NB/2){wsrc[15:0]}};
         MEM_WORD: wdata_d = {(NB/4){wsrc[31:0]}};
         default:  wdata_d = wsrc;
      endcase
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         MEM_IDLE: if (start && !misalign) state_d = MEM_REQ;
         MEM_REQ:  if (mem_ready)          state_d = MEM_RESP;
         MEM_RESP:                         state_d = MEM_IDLE;
         default:                          state_d = MEM_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= MEM_IDLE;
         fault_q <= 1'b0;
         we_q    <= 1'b0;
         uns_q   <= 1'b0;
         dst_q   <= 1'b0;
         width_q <= 2'd0;
         off_q   <= '0;
         addr_q  <= '0;
         be_q    <= '0;
         wdata_q <= '0;
      end else begin
         state_q <= state_d;
         // A faulting start never leaves IDLE; it only produces a done+fault pulse.
         fault_q <= (state_q == MEM_IDLE) && start && misalign;
         if (accept) begin
            we_q    <= we;
            uns_q   <= uns;
            dst_q   <= dst;
            width_q <= width;
            off_q   <= off;
            addr_q  <= {addr[XLEN-1:OFFW], {OFFW{1'b0}}};
            be_q    <= be_d;
            wdata_q <= wdata_d;
         end
      end
   end

   // Load extraction: move the addressed lane to bit 0, then extend.
   assign shifted = mem_rdata >> {off_q, 3'b000};

   always_comb begin
      keep = '1;
      msb  = shifted[XLEN-1];
      case (width_q)
         MEM_BYTE: begin keep = XLEN'(8'hFF);         msb = shifted[7];  end
         MEM_HALF: begin keep = XLEN'(16'hFFFF);      msb = shifted[15]; end
         MEM_WORD: begin keep = XLEN'(32'hFFFF_FFFF); msb = shifted[31]; end
         default:  ;
      endcase
      load_dat = (shifted & keep) | (~keep & {XLEN{msb & ~uns_q}});
   end

   assign busy      = (state_q != MEM_IDLE);
   assign mem_valid = (state_q == MEM_REQ);
   assign mem_we    = we_q && mem_valid;
   assign mem_addr  = addr_q;
   assign mem_be    = be_q;
   assign mem_wdata = wdata_q;
   assign done      = (state_q == MEM_RESP) || fault_q;
   assign fault     = fault_q;
   assign load_vld  = mem_valid && mem_ready && !we_q;
   assign load_dst  = dst_q;

endmodule

// File: rtl/datapath_mc.sv
// Multicycle core datapath: PC, IR, MDR, ALU_R, register file, ALU and memory sequencer.
// Latency: regfile reads and ALU combinational; all state updates on the next rising edge.
// Backpressure: memory accesses stall in the sequencer until mem_ready; ctl_mem_start ignored while busy.
// Ports: ctl_* from the control FSM; pc/ir/alu_zero/mem_busy/mem_done/mem_fault status; mem_* memory channel.
module datapath_mc
   import datapath_mc_types::*;
#(
   parameter int              XLEN     = 32,
   parameter int              NREGS    = 32,
   parameter logic [XLEN-1:0] RESET_PC = '0
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic [$clog2(NREGS)-1:0] ctl_rs1,
   input  logic [$clog2(NREGS)-1:0] ctl_rs2,
   input  logic [$clog2(NREGS)-1:0] ctl_rd,
   input  logic                     ctl_rf_we,
   input  logic [1:0]               ctl_rf_d_sel,
   input  logic                     ctl_alu_x_sel,
   input  logic                     ctl_alu_y_sel,
   input  logic [3:0]               ctl_alu_op,
   input  logic [XLEN-1:0]          ctl_immed,
   input  logic                     ctl_alu_r_we,
   input  logic                     ctl_pc_we,
   input  logic                     ctl_pc_sel,
   input  logic                     ctl_mem_start,
   input  logic                     ctl_mem_we,
   input  logic                     ctl_mem_addr_sel,
   input  logic [1:0]               ctl_mem_width,
   input  logic                     ctl_mem_unsigned,
   input  logic                     ctl_mem_dst,
   output logic [XLEN-1:0]          pc,
   output logic [XLEN-1:0]          ir,
   output logic                     alu_zero,
   output logic                     mem_busy,
   output logic                     mem_done,
   output logic                     mem_fault,
   output logic                     mem_valid,
   input  logic                     mem_ready,
   output logic                     mem_we,
   output logic [XLEN-1:0]          mem_addr,
   output logic [XLEN/8-1:0]        mem_be,
   output logic [XLEN-1:0]          mem_wdata,
   input  logic [XLEN-1:0]          mem_rdata
);

   logic [XLEN-1:0] pc_q, ir_q, mdr_q, alu_r_q;
   logic [XLEN-1:0] rf_q [NREGS];

   logic [XLEN-1:0] rs1_dat, rs2_dat, rf_d;
   logic [XLEN-1:0] alu_x, alu_y, alu_w, mem_addr_d;
   logic            load_vld, load_dst;
   logic [XLEN-1:0] load_dat;

   // Reads see the pre-edge contents: a register written this cycle reads old data.
   assign rs1_dat = (ctl_rs1 == '0) ? '0 : rf_q[ctl_rs1];
   assign rs2_dat = (ctl_rs2 == '0) ? '0 : rf_q[ctl_rs2];

   always_comb begin
      case (ctl_rf_d_sel)
         RF_D_ALU_R: rf_d = alu_r_q;
         RF_D_MDR:   rf_d = mdr_q;
         default:    rf_d = alu_w;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < NREGS; i++) rf_q[i] <= '0;
      end else if (ctl_rf_we && (ctl_rd != '0)) begin
         rf_q[ctl_rd] <= rf_d;
      end
   end

   assign alu_x = (ctl_alu_x_sel == ALU_X_PC)    ? pc_q      : rs1_dat;
   assign alu_y = (ctl_alu_y_sel == ALU_Y_IMMED) ? ctl_immed : rs2_dat;

   alu #(.XLEN(XLEN)) u_alu (
      .op (ctl_alu_op),
      .x  (alu_x),
      .y  (alu_y),
      .w  (alu_w)
   );

   assign alu_zero   = (alu_w == '0);
   assign mem_addr_d = (ctl_mem_addr_sel == MEM_ADDR_ALU_R) ? alu_r_q : pc_q;

   // MDR capture and an RF_D_MDR write on the same edge: the regfile takes the old MDR.
   always_ff @(posedge clk) begin
      if (rst) begin
         pc_q    <= RESET_PC;
         ir_q    <= '0;
         mdr_q   <= '0;
         alu_r_q <= '0;
      end else begin
         if (ctl_alu_r_we) alu_r_q <= alu_w;
         if (ctl_pc_we)    pc_q    <= ctl_pc_sel ? alu_r_q : alu_w;
         if (load_vld) begin
            if (load_dst == MEM_DST_MDR) mdr_q <= load_dat;
            else                         ir_q  <= load_dat;
         end
      end
   end

   mem_sequencer #(.XLEN(XLEN)) u_mem_seq (
      .clk       (clk),
      .rst       (rst),
      .start     (ctl_mem_start),
      .we        (ctl_mem_we),
      .addr      (mem_addr_d),
      .wsrc      (rs2_dat),
      .width     (ctl_mem_width),
      .uns       (ctl_mem_unsigned),
      .dst       (ctl_mem_dst),
      .busy      (mem_busy),
      .done      (mem_done),
      .fault     (mem_fault),
      .mem_valid (mem_valid),
      .mem_ready (mem_ready),
      .mem_we    (mem_we),
      .mem_addr  (mem_addr),
      .mem_be    (mem_be),
      .mem_wdata (mem_wdata),
      .mem_rdata (mem_rdata),
      .load_vld  (load_vld),
      .load_dst  (load_dst),
      .load_dat  (load_dat)
   );

   assign pc = pc_q;
   assign ir = ir_q;

endmodule

// File: doc/datapath_mc.md
Name: datapath_mc

Overview:
- Parametrised multicycle successor of the single-cycle core datapath.
- Holds the architectural PC, an instruction register (IR), a memory data register (MDR), an ALU result register (ALU_R) and the register file.
- Runs a valid/ready memory sequencer with misalignment detection, byte-lane steering and load extension.
- Sits between the core control FSM (ctl_* inputs) and the memory subsystem (mem_* ports).

Parameters:
XLEN, 32, data/address width; legal values 32 or 64.
NREGS, 32, number of architectural registers; x0 hardwired to zero.
RESET_PC, 0, PC value after reset.

Ports:
clk  in  1  clock, all state on rising edge
rst  in  1  synchronous active-high reset
ctl_rs1, ctl_rs2, ctl_rd  in  $clog2(NREGS) each  register addresses
ctl_rf_we  in  1  regfile write enable
ctl_rf_d_sel  in  2  regfile write source: RF_D_ALU_R, RF_D_MDR, RF_D_ALU_W
ctl_alu_x_sel  in  1  ALU_X_REGFILE or ALU_X_PC
ctl_alu_y_sel  in  1  ALU_Y_REGFILE or ALU_Y_IMMED
ctl_alu_op  in  4  ALU operation
ctl_immed  in  XLEN  immediate
ctl_alu_r_we  in  1  capture ALU result into ALU_R
ctl_pc_we, ctl_pc_sel  in  1 each  PC update; sel 0 = alu_w, 1 = ALU_R
ctl_mem_start  in  1  start memory access (pulse)
ctl_mem_we  in  1  access is a store
ctl_mem_addr_sel  in  1  MEM_ADDR_PC or MEM_ADDR_ALU_R
ctl_mem_width  in  2  BYTE, HALF, WORD, DWORD
ctl_mem_unsigned  in  1  zero-extend on load
ctl_mem_dst  in  1  load destination: IR or MDR
pc, ir  out  XLEN  architectural PC, instruction register
alu_zero  out  1  alu_w == 0
mem_busy  out  1  sequencer not IDLE
mem_done  out  1  one-cycle completion pulse
mem_fault  out  1  misaligned or illegal width; valid only with mem_done
mem_valid  out  1  request valid
mem_ready  in  1  memory accepts/completes the request
mem_we  out  1  write request
mem_addr  out  XLEN  naturally aligned to XLEN/8 bytes (low bits zeroed)
mem_be  out  XLEN/8  byte enables
mem_wdata  out  XLEN  store data, lane-replicated
mem_rdata  in  XLEN  load data, sampled when mem_valid && mem_ready

Behaviour:
- Reset values: pc=RESET_PC; ir, MDR, ALU_R and all registers = 0; sequencer IDLE; mem_valid, mem_we, mem_done, mem_fault = 0; mem_addr, mem_be, mem_wdata = 0.
- Reset mid-access: request is abandoned and mem_valid is 0 from the next cycle. Memory tolerates abandoned requests.
- Regfile:
  - Reads are combinational.
  - Write happens at the edge when ctl_rf_we && ctl_rd != 0.
  - Reads of x0 return 0.
  - Same-cycle read of the register being written returns the old value; no bypass.
- ALU path:
  - alu_w is combinational from the selected operands.
  - ALU_R <= alu_w when ctl_alu_r_we.
  - PC <= (ctl_pc_sel ? ALU_R : alu_w) when ctl_pc_we.
- Sequencer FSM states: IDLE, REQ, RESP.
- IDLE:
  - On ctl_mem_start, compute addr from ctl_mem_addr_sel.
  - Fault condition: HALF with addr[0] != 0; WORD with addr[1:0] != 0; DWORD with addr[2:0] != 0 or XLEN=32.
  - On fault: next cycle mem_done=1 and mem_fault=1; no request issued; stay IDLE.
  - Otherwise latch we, width, unsigned, dst, byte offset, be and wdata; go REQ.
- REQ:
  - mem_valid=1; all mem_* outputs held stable.
  - On mem_ready: for loads, write the extracted value into IR or MDR; go RESP.
- RESP: mem_done=1 for one cycle; go IDLE.
- ctl_mem_start is ignored unless IDLE.
- Minimum latency: start at cycle N, mem_valid at N+1; with ready at N+1, mem_done at N+2.
- Store steering: mem_wdata replicates rs2 low bits (BYTE: XLEN/8 copies of [7:0]; HALF: [15:0]; and so on). mem_be = width mask << byte offset.
- Load extraction: mem_rdata >> (8*offset), truncated to the access width, then sign- or zero-extended to XLEN.
- Same-edge capture and use: if the MDR capture and an RF_D_MDR regfile write share an edge, the regfile receives the old MDR.

Decomposition:
- Package datapath_mc_types holds:
  - enums rf_d_sel_t, alu_x_sel_t, alu_y_sel_t, mem_addr_sel_t, mem_width_t, mem_dst_t, mem_state_t;
  - the ALU op encoding;
  - a width-to-byte-mask function.
- The existing alu is instantiated unchanged, widened to XLEN.
- One natural sub-module, mem_sequencer: FSM, alignment check, be/wdata steering, load extraction.

Test Plan:
- Reset, then fetch with ctl_mem_start, MEM_ADDR_PC, WORD, dst=IR, ready after 3 wait cycles, rdata=0x00500093 -> ir=0x00500093; mem_done pulses exactly once, 5 cycles after start.
- Load byte signed at addr 0x1003, rdata=0x80FFFFFF -> MDR=0xFFFFFF80; with unsigned set -> MDR=0x00000080; mem_be=4'b1000.
- Store half at 0x2002 with rs2=0x1234ABCD -> mem_wdata=0xABCDABCD, mem_be=4'b1100, mem_addr=0x2000, mem_we=1 held until ready.
- Word access at 0x2001 -> no mem_valid; mem_done and mem_fault both 1 on the next cycle.
- Write x0 with 0xDEADBEEF, then read x0 -> 0. Write x5 and read it in the same cycle -> old value, new value on the following cycle.
- Assert rst while in REQ with ready held low -> mem_valid=0 next cycle, pc=RESET_PC, mem_done never pulses.
